// File: rtl/vga_scan_out.sv
// vga_scan_out: 640x480@60 raster timing and DAC output stage, pins lag pix_x/pix_y by PIPE_LAT+1 pixel ticks.
// Free-running, no backpressure; defining VGA_TEST_PATTERN_EN adds a test_mode colour-bar input.
module vga_scan_out #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIPE_LAT  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic       pix_en,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_valid,
  output logic       frame_start,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int BAR_W   = H_VISIBLE / 8;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vis;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
  } tap_t;

`ifdef VGA_TEST_PATTERN_EN
  localparam tap_t TAP_RST = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, bar: 3'd0};
`else
  localparam tap_t TAP_RST = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};
`endif

  logic       phase;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  tap_t       raw;
  tap_t       tap;
  logic [23:0] rgb_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end

  // Line and frame wrap share the same pix_en, so (H_LAST, V_LAST) goes straight to (0, 0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (phase) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign pix_en      = phase;
  assign vga_clk     = ~phase;
  assign pix_x       = h_cnt;
  assign pix_y       = v_cnt;
  assign pix_valid   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_start = phase && (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign vga_sync_n  = 1'b0;

  always_comb begin
    raw     = TAP_RST;
    raw.hs  = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
    raw.vs  = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
    raw.vis = pix_valid;
`ifdef VGA_TEST_PATTERN_EN
    // Bar index saturates past the visible area; blanking hides it there.
    for (int i = 1; i < 8; i++) begin
      if (h_cnt >= 10'(i * BAR_W)) raw.bar = 3'(i);
    end
`endif
  end

  generate
    if (PIPE_LAT == 0) begin : g_no_dly
      assign tap = raw;
    end else begin : g_dly
      tap_t stg [PIPE_LAT];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_LAT; i++) stg[i] <= TAP_RST;
        end else if (phase) begin
          stg[0] <= raw;
          for (int i = 1; i < PIPE_LAT; i++) stg[i] <= stg[i-1];
        end
      end

      assign tap = stg[PIPE_LAT-1];
    end
  endgenerate

  always_comb begin
    rgb_nxt = 24'h000000;
    if (tap.vis) begin
      rgb_nxt = {r_in, g_in, b_in};
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode) rgb_nxt = {{8{tap.bar[2]}}, {8{tap.bar[1]}}, {8{tap.bar[0]}}};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
    end else if (phase) begin
      vga_hs      <= tap.hs;
      vga_vs      <= tap.vs;
      vga_blank_n <= tap.vis;
      {vga_r, vga_g, vga_b} <= rgb_nxt;
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: four instances (PIPE_LAT 2/0/4 at 640x480, one tiny raster) against an arithmetic raster model.
module tb_vga_scan_out;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n;
  logic tmode;
  logic [7:0] ri [4];
  logic [7:0] gi [4];
  logic [7:0] bi [4];
  logic       pe [4];
  logic       vc [4];
  logic       hs [4];
  logic       vs [4];
  logic       bn [4];
  logic       sn [4];
  logic       pv [4];
  logic       fs [4];
  logic [9:0] px [4];
  logic [9:0] py [4];
  logic [7:0] ro [4];
  logic [7:0] go [4];
  logic [7:0] bo [4];

  // Per-instance raster parameters: 0 = lat 2, 1 = lat 0, 2 = lat 4, 3 = tiny raster lat 1
  int HV [4] = '{640, 640, 640, 16};
  int HF [4] = '{16, 16, 16, 2};
  int HS [4] = '{96, 96, 96, 4};
  int HB [4] = '{48, 48, 48, 3};
  int VV [4] = '{480, 480, 480, 8};
  int VF [4] = '{10, 10, 10, 1};
  int VS [4] = '{2, 2, 2, 2};
  int VB [4] = '{33, 33, 33, 2};
  int LT [4] = '{2, 0, 4, 1};

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int e = 0;
  int hs_lo = 0;
  int vs_lo = 0;
  int sm_cnt = 0;
  int fs_seen = 0;

  vga_scan_out u_l2 (
    .clk(clk), .rst_n(rst_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tmode),
`endif
    .r_in(ri[0]), .g_in(gi[0]), .b_in(bi[0]),
    .pix_en(pe[0]), .pix_x(px[0]), .pix_y(py[0]), .pix_valid(pv[0]), .frame_start(fs[0]),
    .vga_clk(vc[0]), .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_blank_n(bn[0]), .vga_sync_n(sn[0]),
    .vga_r(ro[0]), .vga_g(go[0]), .vga_b(bo[0])
  );

  vga_scan_out #(.PIPE_LAT(0)) u_l0 (
    .clk(clk), .rst_n(rst_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .r_in(ri[1]), .g_in(gi[1]), .b_in(bi[1]),
    .pix_en(pe[1]), .pix_x(px[1]), .pix_y(py[1]), .pix_valid(pv[1]), .frame_start(fs[1]),
    .vga_clk(vc[1]), .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_blank_n(bn[1]), .vga_sync_n(sn[1]),
    .vga_r(ro[1]), .vga_g(go[1]), .vga_b(bo[1])
  );

  vga_scan_out #(.PIPE_LAT(4)) u_l4 (
    .clk(clk), .rst_n(rst_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .r_in(ri[2]), .g_in(gi[2]), .b_in(bi[2]),
    .pix_en(pe[2]), .pix_x(px[2]), .pix_y(py[2]), .pix_valid(pv[2]), .frame_start(fs[2]),
    .vga_clk(vc[2]), .vga_hs(hs[2]), .vga_vs(vs[2]), .vga_blank_n(bn[2]), .vga_sync_n(sn[2]),
    .vga_r(ro[2]), .vga_g(go[2]), .vga_b(bo[2])
  );

  vga_scan_out #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .PIPE_LAT(1)
  ) u_sm (
    .clk(clk), .rst_n(rst_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .r_in(ri[3]), .g_in(gi[3]), .b_in(bi[3]),
    .pix_en(pe[3]), .pix_x(px[3]), .pix_y(py[3]), .pix_valid(pv[3]), .frame_start(fs[3]),
    .vga_clk(vc[3]), .vga_hs(hs[3]), .vga_vs(vs[3]), .vga_blank_n(bn[3]), .vga_sync_n(sn[3]),
    .vga_r(ro[3]), .vga_g(go[3]), .vga_b(bo[3])
  );

  function automatic int ht(int d);
    return HV[d] + HF[d] + HS[d] + HB[d];
  endfunction

  function automatic int vt(int d);
    return VV[d] + VF[d] + VS[d] + VB[d];
  endfunction

  // Colour the draw logic supplies for raster position index j (FF outside the picture).
  function automatic logic [23:0] col(int d, int j);
    int x, y;
    if (j < 0) return 24'hFFFFFF;
    x = j % ht(d);
    y = (j / ht(d)) % vt(d);
    if (x >= HV[d] || y >= VV[d]) return 24'hFFFFFF;
    return {8'(x), 8'(y) ^ 8'h3C, 8'(x + y)};
  endfunction

  // Expected outputs ee clk edges after reset release: pulse n presents index n,
  // pins show the index presented PIPE_LAT+1 pulses earlier.
  function automatic logic [51:0] expect_vec(int d, int ee);
    int ph, n, x, y, j, xj, yj;
    logic vis, fsv, hsv, vsv, bnv;
    logic [2:0] bar;
    logic [23:0] rgb;
    ph  = ee % 2;
    n   = ee / 2;
    x   = n % ht(d);
    y   = (n / ht(d)) % vt(d);
    vis = (x < HV[d]) && (y < VV[d]);
    fsv = (ph == 1) && (x == 0) && (y == 0);
    j   = n - 1 - LT[d];
    hsv = 1'b1;
    vsv = 1'b1;
    bnv = 1'b0;
    rgb = 24'h0;
    if (j >= 0) begin
      xj  = j % ht(d);
      yj  = (j / ht(d)) % vt(d);
      hsv = !(xj >= HV[d] + HF[d] && xj < HV[d] + HF[d] + HS[d]);
      vsv = !(yj >= VV[d] + VF[d] && yj < VV[d] + VF[d] + VS[d]);
      bnv = (xj < HV[d]) && (yj < VV[d]);
      if (bnv) begin
        bar = 3'(xj / 80);
        if (d == 0 && tmode) rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
        else rgb = col(d, j);
      end
    end
    return {10'(x), 10'(y), vis, fsv, 1'(ph), ~1'(ph), hsv, vsv, bnv, 1'b0, rgb};
  endfunction

  task automatic chk(input string name, input logic [51:0] act, input logic [51:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    logic r;
    int ph, n;
    r = rst_n;
    @(posedge clk);
    #2;
    if (!r) begin
      e = 0; hs_lo = 0; vs_lo = 0; sm_cnt = 0; fs_seen = 0;
    end else e++;
    ph = e % 2;
    n  = e / 2;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("dut%0d e=%0d", d, e),
          {px[d], py[d], pv[d], fs[d], pe[d], vc[d], hs[d], vs[d], bn[d], sn[d], ro[d], go[d], bo[d]},
          expect_vec(d, e));
    end
    if (e == 1) begin
      chk("rel_fs", 52'(fs[0]), 52'd1);
      chk("rel_xy", 52'({px[0], py[0]}), 52'd0);
      chk("rel_sync", 52'({hs[0], vs[0]}), 52'd3);
    end
    if (ph == 1) begin
      if (n == 13 && !tmode) chk("pix10_r", 52'(ro[0]), 52'd10);
      if (n == 703) chk("hblank_rgb", 52'({bn[0], ro[0], go[0], bo[0]}), 52'd0);
      if (n == 656) chk("l0_hs_pre", 52'(hs[1]), 52'd1);
      if (n == 657) chk("l0_hs_fall", 52'(hs[1]), 52'd0);
      if (n == 660) chk("l4_hs_pre", 52'(hs[2]), 52'd1);
      if (n == 661) chk("l4_hs_fall", 52'(hs[2]), 52'd0);
      if (n < 800) begin
        if (!hs[0]) hs_lo++;
      end else if (n == 800) chk("hs_width", 52'(hs_lo), 52'd96);
      if (fs[3]) begin
        if (fs_seen == 1) begin
          chk("frame_len", 52'(sm_cnt), 52'd325);
          chk("vs_width", 52'(vs_lo), 52'd50);
        end
        fs_seen++;
        sm_cnt = 0;
        vs_lo  = 0;
      end
      sm_cnt++;
      if (!vs[3]) vs_lo++;
    end
    for (int d = 0; d < 4; d++) {ri[d], gi[d], bi[d]} = col(d, n - LT[d]);
    if (n_fail > 200) begin
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  endtask

  task automatic run_until(input int target);
    logic reached;
    reached = 1'b0;
    for (int k = 0; k < 2 * target + 8; k++) begin
      step();
      if (e % 2 == 1 && e / 2 == target) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) chk("run_until_timeout", 52'd0, 52'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    tmode = 1'b0;
    for (int d = 0; d < 4; d++) begin
      ri[d] = 8'h00; gi[d] = 8'h00; bi[d] = 8'h00;
    end
    repeat (3) step();
    rst_n = 1'b1;
    run_until(2 * 800 + 320);
    chk("pre_rst_xy", 52'({px[0], py[0]}), 52'({10'd320, 10'd2}));
    rst_n = 1'b0;
    step();
    chk("mid_rst_state", 52'({px[0], py[0], bn[0], ro[0], go[0], bo[0]}), 52'd0);
    rst_n = 1'b1;
    run_until(1000);
    chk("frames_seen", 52'(fs_seen >= 2), 52'd1);
`ifdef VGA_TEST_PATTERN_EN
    rst_n = 1'b0;
    tmode = 1'b1;
    step();
    rst_n = 1'b1;
    run_until(10 * 800 + 85 + 3);
    chk("bar1", 52'({ro[0], go[0], bo[0]}), 52'h0000FF);
    run_until(10 * 800 + 600 + 3);
    chk("bar7", 52'({ro[0], go[0], bo[0]}), 52'hFFFFFF);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
